// File: rtl/forward_scoreboard.sv
// forward_scoreboard: tracks in-flight register writes over DEPTH stages, registers youngest-producer
// operand selects for EX and raises a combinational load-use stall. Option macro: ZERO_REG_HARDWIRE_EN.
module forward_scoreboard #(
  parameter  int REG_W      = 2,
  parameter  int DEPTH      = 2,
  parameter  int LOAD_STAGE = 2,
  localparam int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  output logic             stall,
  output logic             ex_valid,
  output logic [SEL_W-1:0] ex_sel_a,
  output logic [SEL_W-1:0] ex_sel_b
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             regwrite;
    logic             memread;
  } entry_t;

  entry_t           p_q [DEPTH];
  logic             hit_a, hit_b, load_hit, accept;
  logic [SEL_W-1:0] sel_a_d, sel_b_d;
  logic             ex_valid_q;
  logic [SEL_W-1:0] ex_sel_a_q, ex_sel_b_q;

  // True when entry e will write register r (and so can supply it).
  function automatic logic writes(entry_t e, logic [REG_W-1:0] r);
`ifdef ZERO_REG_HARDWIRE_EN
    return e.valid && e.regwrite && (e.dest == r) && (e.dest != '0);
`else
    return e.valid && e.regwrite && (e.dest == r);
`endif
  endfunction

  // Walk oldest to youngest so the youngest matching producer overwrites the select last.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that skips an assignment infers a latch.
    sel_a_d  = '0;
    sel_b_d  = '0;
    load_hit = 1'b0;
    hit_a    = 1'b0;
    hit_b    = 1'b0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      hit_a = id_use_rs && writes(p_q[j], id_rs);
      hit_b = id_use_rt && writes(p_q[j], id_rt);
      if (hit_a) sel_a_d = SEL_W'(j + 1);
      if (hit_b) sel_b_d = SEL_W'(j + 1);
      // Load data is not yet available in stages younger than LOAD_STAGE.
      if ((j <= LOAD_STAGE - 2) && p_q[j].memread && (hit_a || hit_b)) load_hit = 1'b1;
    end
  end

  assign stall  = !flush && id_valid && load_hit;
  assign accept = id_valid && !stall && !flush;

  // The pipe shifts every cycle; a stall or flush only injects a bubble at the head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the scoreboard is a handful of flops, not a RAM, so it is cleared on reset; stale valid bits would fake hazards.
      for (int i = 0; i < DEPTH; i++) p_q[i] <= '0;
      ex_valid_q <= 1'b0;
      ex_sel_a_q <= '0;
      ex_sel_b_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage read its neighbour's pre-edge value, so the shift order is irrelevant.
      for (int i = DEPTH - 1; i >= 1; i--) p_q[i] <= p_q[i-1];
      if (accept) begin
        p_q[0].valid    <= 1'b1;
        p_q[0].dest     <= id_dest;
        p_q[0].regwrite <= id_regwrite;
        p_q[0].memread  <= id_memread;
        ex_sel_a_q      <= sel_a_d;
        ex_sel_b_q      <= sel_b_d;
      end else begin
        p_q[0]     <= '0;
        ex_sel_a_q <= '0;
        ex_sel_b_q <= '0;
      end
      ex_valid_q <= accept;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_sel_a = ex_sel_a_q;
  assign ex_sel_b = ex_sel_b_q;

endmodule

// File: tb/tb_forward_scoreboard.sv
// tb_forward_scoreboard: drives a DEPTH=2/REG_W=2 and a DEPTH=3/REG_W=3 scoreboard with the same
// stimulus and checks both against a queue-based history model every cycle, plus directed cases.
module tb_forward_scoreboard;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread, flush;
  logic [2:0] id_rs, id_rt, id_dest;
  logic       stall0, stall1, ev0, ev1;
  logic [1:0] sa0, sb0, sa1, sb1;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  forward_scoreboard #(.REG_W(2), .DEPTH(2), .LOAD_STAGE(2)) dut0 (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_rs(id_rs[1:0]), .id_rt(id_rt[1:0]), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_dest(id_dest[1:0]), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .stall(stall0), .ex_valid(ev0), .ex_sel_a(sa0), .ex_sel_b(sb0)
  );

  forward_scoreboard #(.REG_W(3), .DEPTH(3), .LOAD_STAGE(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_dest(id_dest), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .stall(stall1), .ex_valid(ev1), .ex_sel_a(sa1), .ex_sel_b(sb1)
  );

  // ---------------- reference model ----------------
  // hist[k][0] is the instruction that most recently entered EX (bubbles included).
  typedef struct {bit valid; int dest; bit rw; bit mr;} ins_t;
  ins_t hist [2][$];
  int   depth_of [2] = '{2, 3};
  int   mask_of  [2] = '{3, 7};
  int   load_stage   = 2;
  int   exp_valid [2];
  int   exp_sa    [2];
  int   exp_sb    [2];

  function automatic bit produces(int k, int j, int r);
    ins_t e;
    e = hist[k][j];
`ifdef ZERO_REG_HARDWIRE_EN
    if (e.dest == 0) return 1'b0;
`endif
    return e.valid && e.rw && (e.dest == (r & mask_of[k]));
  endfunction

  function automatic int youngest(int k, bit used, int r);
    if (!used) return 0;
    for (int j = 0; j < hist[k].size(); j++)
      if (produces(k, j, r)) return j + 1;
    return 0;
  endfunction

  function automatic bit load_use(int k);
    if (flush || !id_valid) return 1'b0;
    for (int j = 0; j < hist[k].size(); j++)
      if ((j + 2 <= load_stage) && hist[k][j].mr &&
          ((id_use_rs && produces(k, j, int'(id_rs))) || (id_use_rt && produces(k, j, int'(id_rt)))))
        return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        hist[k].delete();
        exp_valid[k] = 0; exp_sa[k] = 0; exp_sb[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit   acc;
        ins_t e;
        acc          = id_valid && !flush && !load_use(k);
        exp_valid[k] = acc;
        exp_sa[k]    = acc ? youngest(k, id_use_rs, int'(id_rs)) : 0;
        exp_sb[k]    = acc ? youngest(k, id_use_rt, int'(id_rt)) : 0;
        e.valid = acc;
        e.dest  = int'(id_dest) & mask_of[k];
        e.rw    = acc && id_regwrite;
        e.mr    = acc && id_memread;
        hist[k].push_front(e);
        if (hist[k].size() > depth_of[k]) void'(hist[k].pop_back());
      end
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare, away from the rising edge; inputs change at negedge+2.
  always @(negedge clk) begin
    check("stall0", {31'b0, stall0}, {31'b0, load_use(0)});
    check("stall1", {31'b0, stall1}, {31'b0, load_use(1)});
    check("ex_valid0", {31'b0, ev0}, exp_valid[0]);
    check("ex_valid1", {31'b0, ev1}, exp_valid[1]);
    check("ex_sel_a0", {30'b0, sa0}, exp_sa[0]);
    check("ex_sel_b0", {30'b0, sb0}, exp_sb[0]);
    check("ex_sel_a1", {30'b0, sa1}, exp_sa[1]);
    check("ex_sel_b1", {30'b0, sb1}, exp_sb[1]);
  end

  // ---------------- stimulus ----------------
  task automatic drive(bit v, int rs, int rt, bit urs, bit urt, int dest, bit rw, bit mr, bit fl);
    @(negedge clk);
    #2;
    id_valid    = v;
    id_rs       = 3'(rs);
    id_rt       = 3'(rt);
    id_use_rs   = urs;
    id_use_rt   = urt;
    id_dest     = 3'(dest);
    id_regwrite = rw;
    id_memread  = mr;
    flush       = fl;
  endtask

  task automatic nops(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_dest = 0; id_regwrite = 0; id_memread = 0; flush = 0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    #1;
    check("reset_stall", {31'b0, stall0}, 0);
    check("reset_ex_valid", {31'b0, ev0}, 0);
    check("reset_sel_a", {30'b0, sa0}, 0);

    // Back-to-back dependency: ADD r1; ADD r2,r1,r3
    nops(3);
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0);
    drive(1, 1, 3, 1, 1, 2, 1, 0, 0);
    #1 check("b2b_stall", {31'b0, stall0}, 0);
    after_edge();
    check("b2b_sel_a", {30'b0, sa0}, 1);
    check("b2b_sel_b", {30'b0, sb0}, 0);
    check("b2b_valid", {31'b0, ev0}, 1);
    check("b2b_sel_a_d3", {30'b0, sa1}, 1);

    // One instruction between writer and reader
    nops(3);
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 2, 1, 0, 0);
    drive(1, 1, 0, 1, 0, 3, 1, 0, 0);
    after_edge();
    check("gap1_sel_a", {30'b0, sa0}, 2);

    // Two writers of r1: youngest wins
    nops(3);
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0);
    drive(1, 1, 0, 1, 0, 3, 1, 0, 0);
    after_edge();
    check("youngest_sel_a", {30'b0, sa0}, 1);

    // Load-use: LW r2; ADD r3,r2,r1 -> one stall cycle, then select stage 2
    nops(3);
    drive(1, 0, 0, 0, 0, 2, 1, 1, 0);
    drive(1, 2, 1, 1, 1, 3, 1, 0, 0);
    #1 check("lu_stall", {31'b0, stall0}, 1);
    check("lu_stall_d3", {31'b0, stall1}, 1);
    after_edge();
    check("lu_bubble", {31'b0, ev0}, 0);
    drive(1, 2, 1, 1, 1, 3, 1, 0, 0);
    #1 check("lu_release", {31'b0, stall0}, 0);
    after_edge();
    check("lu_sel_a", {30'b0, sa0}, 2);
    check("lu_sel_b", {30'b0, sb0}, 0);
    check("lu_valid", {31'b0, ev0}, 1);

    // Load-use with flush in the same cycle
    nops(3);
    drive(1, 0, 0, 0, 0, 2, 1, 1, 0);
    drive(1, 2, 1, 1, 1, 3, 1, 0, 1);
    #1 check("flush_stall", {31'b0, stall0}, 0);
    after_edge();
    check("flush_valid", {31'b0, ev0}, 0);

    // Asynchronous reset in the middle of a stall
    nops(3);
    drive(1, 0, 0, 0, 0, 2, 1, 1, 0);
    drive(1, 2, 1, 1, 1, 3, 1, 0, 0);
    #1 check("mid_stall", {31'b0, stall0}, 1);
    reset_n = 1'b0;
    #1;
    check("arst_stall", {31'b0, stall0}, 0);
    check("arst_valid", {31'b0, ev0}, 0);
    check("arst_sel_a", {30'b0, sa0}, 0);
    check("arst_sel_b", {30'b0, sb0}, 0);
    @(negedge clk);
    #2 reset_n = 1'b1;

    // Register 0 as producer and consumer
    nops(3);
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 1, 0, 1, 1, 0, 0);
    after_edge();
`ifdef ZERO_REG_HARDWIRE_EN
    check("r0_sel_a", {30'b0, sa0}, 0);
`else
    check("r0_sel_a", {30'b0, sa0}, 1);
`endif

    // Writer three ahead: tracked only by the DEPTH=3 instance
    nops(3);
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 2, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
    drive(1, 1, 0, 1, 0, 4, 1, 0, 0);
    after_edge();
    check("far_sel_a_d3", {30'b0, sa1}, 3);
    check("far_sel_a_d2", {30'b0, sa0}, 0);

    // Randomized traffic, model-checked every cycle
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      #2;
      reset_n     = ($urandom_range(0, 199) != 0);
      id_valid    = ($urandom_range(0, 5) != 0);
      id_rs       = 3'($urandom_range(0, 7));
      id_rt       = 3'($urandom_range(0, 7));
      id_use_rs   = ($urandom_range(0, 3) != 0);
      id_use_rt   = ($urandom_range(0, 2) != 0);
      id_dest     = 3'($urandom_range(0, 7));
      id_regwrite = ($urandom_range(0, 4) != 0);
      id_memread  = ($urandom_range(0, 2) == 0);
      flush       = ($urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
